// File: rtl/ntt_pkg.sv
// Shared types and size derivations for the radix-4 NTT operand sequencer.
// Pure declarations; no timing or flow control involved.
package ntt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_FIN
  } state_t;

  function automatic int calc_len(input int log4_l);
    return 1 << (2 * log4_l);
  endfunction

  function automatic int calc_aw(input int log4_l);
    return 2 * log4_l;
  endfunction

endpackage

// File: rtl/radix_4_ntt_wb_delay.sv
// Resettable shift register matching the butterfly pipeline: DEPTH-cycle latency.
// No backpressure; one word enters and one leaves every cycle.
module radix_4_ntt_wb_delay #(
  parameter int DEPTH = 2,
  parameter int W     = 25
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_dat,
  output logic [W-1:0] o_dat
);

  logic [W-1:0] r_pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_dat;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_dat = r_pipe[DEPTH-1];

endmodule

// File: rtl/radix_4_ntt_ctrl.sv
// Radix-4 DIF NTT operand sequencer: one butterfly read per ISSUE cycle, write-back BF_LAT later.
// No backpressure; a transform runs to completion unless reset, start ignored while busy.
module radix_4_ntt_ctrl
  import ntt_pkg::*;
#(
  parameter  int LOG4_L = 3,
  parameter  int BF_LAT = 2,
  localparam int AW     = calc_aw(LOG4_L)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [LOG4_L-1:0] stage,
  output logic              rd_en,
  output logic [AW-1:0]     rd_addr0,
  output logic [AW-1:0]     rd_addr1,
  output logic [AW-1:0]     rd_addr2,
  output logic [AW-1:0]     rd_addr3,
  output logic [AW-1:0]     tw_e1,
  output logic [AW-1:0]     tw_e2,
  output logic [AW-1:0]     tw_e3,
  output logic              wr_en,
  output logic [AW-1:0]     wr_addr0,
  output logic [AW-1:0]     wr_addr1,
  output logic [AW-1:0]     wr_addr2,
  output logic [AW-1:0]     wr_addr3
);

  localparam int                LEN    = calc_len(LOG4_L);
  localparam int                DW     = 1 + 4 * AW;
  localparam logic [AW-1:0]     B_LAST = AW'(LEN / 4 - 1);
  localparam logic [LOG4_L-1:0] S_LAST = LOG4_L'(LOG4_L - 1);
  localparam logic [2:0]        D_LAST = 3'(BF_LAT - 1);

  state_t            r_state, w_state_nxt;
  logic [AW-1:0]     r_b, w_b_nxt;
  logic [LOG4_L-1:0] r_s, w_s_nxt;
  logic [2:0]        r_d, w_d_nxt;
  logic              w_rd_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_b     <= '0;
      r_s     <= '0;
      r_d     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_b     <= w_b_nxt;
      r_s     <= w_s_nxt;
      r_d     <= w_d_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_b_nxt     = r_b;
    w_s_nxt     = r_s;
    w_d_nxt     = r_d;
    busy        = (r_state != ST_IDLE);
    done        = (r_state == ST_FIN);
    w_rd_en     = (r_state == ST_ISSUE);
    case (r_state)
      ST_IDLE: if (start) begin
        w_state_nxt = ST_ISSUE;
        w_s_nxt     = '0;
        w_b_nxt     = '0;
      end
      ST_ISSUE: if (r_b == B_LAST) begin
        w_state_nxt = ST_DRAIN;
        w_d_nxt     = '0;
      end else begin
        w_b_nxt = r_b + AW'(1);
      end
      // Hold off the next stage until every write-back of this one has landed.
      ST_DRAIN: if (r_d == D_LAST) begin
        if (r_s == S_LAST) begin
          w_state_nxt = ST_FIN;
        end else begin
          w_state_nxt = ST_ISSUE;
          w_s_nxt     = r_s + LOG4_L'(1);
          w_b_nxt     = '0;
        end
      end else begin
        w_d_nxt = r_d + 3'd1;
      end
      ST_FIN: begin
        w_state_nxt = ST_IDLE;
        w_s_nxt     = '0;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // span is a power of four, so g/j split is a mask and base inserts two zero bits above j.
  logic [AW-1:0] w_sh, w_span_m1, w_j, w_base, w_tsh;
  logic [AW-1:0] w_addr [4];
  logic [AW-1:0] w_tw [1:3];

  always_comb begin
    w_sh      = AW'(2 * (LOG4_L - 1)) - (AW'(r_s) << 1);
    w_span_m1 = (AW'(1) << w_sh) - AW'(1);
    w_j       = r_b & w_span_m1;
    w_base    = ((r_b & ~w_span_m1) << 2) | w_j;
    w_tsh     = AW'(r_s) << 1;
    for (int k = 0; k < 4; k++) begin
      w_addr[k] = w_rd_en ? (w_base | (AW'(k) << w_sh)) : '0;
    end
    for (int k = 1; k < 4; k++) begin
      w_tw[k] = w_rd_en ? ((AW'(k) * w_j) << w_tsh) : '0;
    end
  end

  assign stage    = r_s;
  assign rd_en    = w_rd_en;
  assign rd_addr0 = w_addr[0];
  assign rd_addr1 = w_addr[1];
  assign rd_addr2 = w_addr[2];
  assign rd_addr3 = w_addr[3];
  assign tw_e1    = w_tw[1];
  assign tw_e2    = w_tw[2];
  assign tw_e3    = w_tw[3];

  logic [DW-1:0] w_wb_dat;

  radix_4_ntt_wb_delay #(
    .DEPTH (BF_LAT),
    .W     (DW)
  ) u_wb_delay (
    .clk   (clk),
    .rst   (rst),
    .i_dat ({w_rd_en, w_addr[0], w_addr[1], w_addr[2], w_addr[3]}),
    .o_dat (w_wb_dat)
  );

  assign {wr_en, wr_addr0, wr_addr1, wr_addr2, wr_addr3} = w_wb_dat;

endmodule

// File: doc/radix_4_ntt_ctrl.md
RADIX_4_NTT_CTRL -- requirements
Module: radix_4_ntt_ctrl

Interface
REQ-001 Parameter LOG4_L, default 3, meaning transform length L = 4^LOG4_L (64 by default).
REQ-002 Parameter BF_LAT, default 2, meaning butterfly datapath pipeline latency in cycles (1..7).
REQ-003 Derived constant AW = 2*LOG4_L, meaning address and twiddle-exponent width (6 by default).
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 start  input  1  request one full forward DIF NTT; sampled only in IDLE.
REQ-008 busy  output  1  high from the cycle after start is accepted until done.
REQ-009 done  output  1  one-cycle pulse when the last write-back completes.
REQ-010 stage  output  LOG4_L-bit  current stage index s.
REQ-011 rd_en  output  1  issue strobe for one butterfly read.
REQ-012 rd_addr0..rd_addr3  output  AW each  read addresses of butterfly operands a0..a3.
REQ-013 tw_e1..tw_e3  output  AW each  twiddle exponents for tf1..tf3; tf0 is always exponent 0.
REQ-014 wr_en  output  1  write-back strobe.
REQ-015 wr_addr0..wr_addr3  output  AW each  write-back addresses for A0..A3.

Function
REQ-016 FSM states: IDLE, ISSUE, DRAIN, FIN; reset state IDLE.
REQ-017 IDLE->ISSUE when start=1, with s=0 and butterfly counter b=0; start is ignored in every other state.
REQ-018 In ISSUE, rd_en=1 every cycle, b increments by 1, and after b=L/4-1 the FSM goes to DRAIN.
REQ-019 Addressing for stage s: span = L>>(2*(s+1)), g = b/span, j = b%span, base = 4*span*g + j, rd_addrk = base + k*span, for k=0..3.
REQ-020 Twiddles: tw_ek = (k*j*4^s) mod L, truncated to AW bits, for k=1..3.
REQ-021 DRAIN SHALL last exactly BF_LAT cycles with rd_en=0, so no stage reads data before its preceding stage has written it.
REQ-022 On DRAIN exit, if s<LOG4_L-1 then s increments, b=0 and the FSM goes to ISSUE; otherwise it goes to FIN.
REQ-023 FIN SHALL last one cycle with done=1, then return to IDLE; stage returns to 0.
REQ-024 wr_en and wr_addr0..3 SHALL equal rd_en and rd_addr0..3 delayed by exactly BF_LAT cycles.
REQ-025 The last wr_en of each stage SHALL coincide with the final DRAIN cycle.
REQ-026 Latency from the start-accept edge to the done pulse SHALL be LOG4_L*(L/4+BF_LAT)+1 cycles (55 by default).
REQ-027 All address arithmetic SHALL be modulo 2^AW with no overflow possible for legal parameters.

Reset
REQ-028 rst=1 SHALL force IDLE; busy, done, rd_en and wr_en are 0; stage, all addresses and exponents are 0; the delay line is cleared.
REQ-029 Reset asserted mid-transform SHALL abort it, with no further wr_en pulses and no done pulse.
REQ-030 start held high during reset is ignored; it is accepted on the first cycle after rst deasserts.

Structure
REQ-031 Shared package ntt_pkg SHALL hold the state enum and the L/AW derivation functions.
REQ-032 Sub-module radix_4_ntt_wb_delay SHALL implement the BF_LAT-deep write-back delay line, which is resettable.
REQ-033 The controller SHALL contain no arithmetic on data; it only drives radix_4_dif_ntt operand sequencing.

Verification
REQ-034 Stage 0 check, default parameters: b=0 gives addresses 0,16,32,48 and exponents 0,0,0; b=1 gives 1,17,33,49 and exponents 1,2,3.
REQ-035 Stage 1 check: b=5 gives addresses 17,21,25,29 and exponents 4,8,12.
REQ-036 Stage 2 check: b=7 gives addresses 28,29,30,31 and exponents 0,0,0; every stage covers all 64 addresses exactly once.
REQ-037 Timing: pulse start once. Required: 48 rd_en, 48 wr_en, each wr_en exactly 2 cycles after its read, and done in cycle 55 after acceptance.
REQ-038 start pulses during busy: ignored, with no restart and identical counts. Reset asserted at cycle 20: outputs zero next cycle, no done, and a new start afterwards runs clean.
REQ-039 Golden model: 64-point sequence through the controller plus radix_4_dif_ntt (Q=65537), then bit-reversed (base-4) readout, matches the software NTT.
